// File: rtl/rps_match_sequencer.sv
// Best-of-N Rock-Paper-Scissors match controller: per-round choice wait, lock-in
// countdown, computer-choice lock pulse, scoring, result display and match end.
module rps_match_sequencer #(
  parameter int WIN_TARGET       = 3,
  parameter int COUNTDOWN_CYCLES = 4,
  parameter int SHOW_CYCLES      = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic [1:0] player_choice,
  input  logic [1:0] computer_choice,
  output logic       stop_signal,
  output logic       clear_choice,
  output logic       win_led,
  output logic       lose_led,
  output logic       tie_led,
  output logic [2:0] player_score,
  output logic [2:0] computer_score,
  output logic       match_over,
  output logic       match_winner
);

  localparam int CW = (COUNTDOWN_CYCLES > 1) ? $clog2(COUNTDOWN_CYCLES) : 1;
  localparam int SW = (SHOW_CYCLES > 1) ? $clog2(SHOW_CYCLES) : 1;
  localparam logic [CW-1:0] CD_LOAD   = CW'(COUNTDOWN_CYCLES - 1);
  localparam logic [SW-1:0] SHOW_LOAD = SW'(SHOW_CYCLES - 1);
  localparam logic [2:0]    TARGET    = 3'(WIN_TARGET);

  typedef enum logic [2:0] {
    IDLE, WAIT_CHOICE, COUNTDOWN, LOCK, EVAL, SHOW, DONE
  } state_t;

  state_t        state_reg, state_next;
  logic [CW-1:0] cd_reg, cd_next;
  logic [SW-1:0] show_reg, show_next;
  logic [1:0]    p_lock_reg, p_lock_next;
  logic [2:0]    leds_reg, leds_next;  // {win, lose, tie}
  logic [2:0]    ps_reg, ps_next;
  logic [2:0]    cs_reg, cs_next;
  logic          stop_reg, stop_next;
  logic          clear_reg, clear_next;
  logic          over_reg, over_next;
  logic          winner_reg, winner_next;

  logic player_wins;
  logic round_tie;

  assign round_tie   = (p_lock_reg == computer_choice);
  assign player_wins = (p_lock_reg == 2'b01 && computer_choice == 2'b11) ||
                       (p_lock_reg == 2'b10 && computer_choice == 2'b01) ||
                       (p_lock_reg == 2'b11 && computer_choice == 2'b10);

  always_comb begin
    state_next  = state_reg;
    cd_next     = cd_reg;
    show_next   = show_reg;
    p_lock_next = p_lock_reg;
    leds_next   = leds_reg;
    ps_next     = ps_reg;
    cs_next     = cs_reg;

    case (state_reg)
      IDLE: begin
        leds_next = 3'b000;
        if (start) begin
          ps_next    = 3'd0;
          cs_next    = 3'd0;
          state_next = WAIT_CHOICE;
        end
      end
      WAIT_CHOICE: begin
        leds_next = 3'b000;
        if (player_choice != 2'b00) begin
          cd_next    = CD_LOAD;
          state_next = COUNTDOWN;
        end
      end
      COUNTDOWN: begin
        // A drop back to "none" beats the counter reaching zero.
        if (player_choice == 2'b00) begin
          state_next = WAIT_CHOICE;
        end else if (cd_reg == '0) begin
          p_lock_next = player_choice;
          state_next  = LOCK;
        end else begin
          cd_next = cd_reg - CW'(1);
        end
      end
      LOCK: begin
        state_next = EVAL;
      end
      EVAL: begin
        // Computer choice not ready yet: retry the lock pulse.
        if (computer_choice == 2'b00) begin
          state_next = LOCK;
        end else begin
          if (round_tie) begin
            leds_next = 3'b001;
          end else if (player_wins) begin
            leds_next = 3'b100;
            ps_next   = ps_reg + 3'd1;
          end else begin
            leds_next = 3'b010;
            cs_next   = cs_reg + 3'd1;
          end
          show_next  = SHOW_LOAD;
          state_next = SHOW;
        end
      end
      SHOW: begin
        if (show_reg == '0) begin
          leds_next  = 3'b000;
          state_next = (ps_reg == TARGET || cs_reg == TARGET) ? DONE : WAIT_CHOICE;
        end else begin
          show_next = show_reg - SW'(1);
        end
      end
      DONE: begin
        leds_next = 3'b000;
        if (start) begin
          ps_next    = 3'd0;
          cs_next    = 3'd0;
          state_next = WAIT_CHOICE;
        end
      end
      default: begin
        leds_next  = 3'b000;
        state_next = IDLE;
      end
    endcase

    // Pulses and flags are registered from the upcoming state so they align with it.
    stop_next   = (state_next == LOCK);
    clear_next  = (state_next == SHOW) && (show_next == '0);
    over_next   = (state_next == DONE);
    winner_next = (state_next == DONE) && (ps_next == TARGET);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg  <= IDLE;
      cd_reg     <= '0;
      show_reg   <= '0;
      p_lock_reg <= 2'b00;
      leds_reg   <= 3'b000;
      ps_reg     <= 3'd0;
      cs_reg     <= 3'd0;
      stop_reg   <= 1'b0;
      clear_reg  <= 1'b0;
      over_reg   <= 1'b0;
      winner_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      cd_reg     <= cd_next;
      show_reg   <= show_next;
      p_lock_reg <= p_lock_next;
      leds_reg   <= leds_next;
      ps_reg     <= ps_next;
      cs_reg     <= cs_next;
      stop_reg   <= stop_next;
      clear_reg  <= clear_next;
      over_reg   <= over_next;
      winner_reg <= winner_next;
    end
  end

  assign stop_signal    = stop_reg;
  assign clear_choice   = clear_reg;
  assign win_led        = leds_reg[2];
  assign lose_led       = leds_reg[1];
  assign tie_led        = leds_reg[0];
  assign player_score   = ps_reg;
  assign computer_score = cs_reg;
  assign match_over     = over_reg;
  assign match_winner   = winner_reg;

endmodule

// File: tb/tb_rps_match_sequencer.sv
// Scoreboard bench for rps_match_sequencer: stimulus pushes timed expected events,
// a negedge monitor pops and compares them as the DUT produces them.
module tb_rps_match_sequencer;
  localparam int C = 4;
  localparam int S = 8;

  localparam int K_STOP   = 0;
  localparam int K_LEDON  = 1;
  localparam int K_CLR    = 2;
  localparam int K_LEDOFF = 3;
  localparam int K_DONE   = 4;

  typedef struct {
    int         kind;
    int         cyc;
    logic [8:0] data;
  } ev_t;

  logic       clock = 1'b0;
  logic       reset;
  logic       start;
  logic [1:0] player_choice;
  logic [1:0] computer_choice;
  logic       stop_signal, clear_choice, win_led, lose_led, tie_led;
  logic [2:0] player_score, computer_score;
  logic       match_over, match_winner;

  ev_t  sb[$];
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  bit   mon_en = 1'b0;
  logic [2:0] leds_prev = 3'b000;
  logic       over_prev = 1'b0;
  wire  [2:0] leds_now = {win_led, lose_led, tie_led};

  rps_match_sequencer dut (
    .clock          (clock),
    .reset          (reset),
    .start          (start),
    .player_choice  (player_choice),
    .computer_choice(computer_choice),
    .stop_signal    (stop_signal),
    .clear_choice   (clear_choice),
    .win_led        (win_led),
    .lose_led       (lose_led),
    .tie_led        (tie_led),
    .player_score   (player_score),
    .computer_score (computer_score),
    .match_over     (match_over),
    .match_winner   (match_winner)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  function automatic string kname(input int k);
    case (k)
      K_STOP:   return "stop";
      K_LEDON:  return "led_on";
      K_CLR:    return "clear";
      K_LEDOFF: return "led_off";
      default:  return "done";
    endcase
  endfunction

  function automatic logic [13:0] outs();
    return {stop_signal, clear_choice, win_led, lose_led, tie_led,
            player_score, computer_score, match_over, match_winner};
  endfunction

  task automatic push(input int kind, input int t, input logic [8:0] d);
    ev_t e;
    e.kind = kind;
    e.cyc  = t;
    e.data = d;
    sb.push_back(e);
  endtask

  task automatic observe(input int kind, input logic [8:0] d);
    ev_t e;
    tests++;
    if (sb.size() == 0) begin
      fails++;
      $display("FAIL unexpected_%s @%0d: got data=%h, required no event", kname(kind), cyc, d);
    end else begin
      e = sb.pop_front();
      if (e.kind != kind || e.cyc != cyc || e.data !== d) begin
        fails++;
        $display("FAIL event_%s: got %s @%0d data=%h, required %s @%0d data=%h",
                 kname(e.kind), kname(kind), cyc, d, kname(e.kind), e.cyc, e.data);
      end
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s @%0d: got %h, required %h", name, cyc, act, exp);
    end
  endtask

  // Event monitor
  always @(negedge clock) begin
    if (mon_en) begin
      if (stop_signal) observe(K_STOP, 9'd0);
      if (leds_now != 3'b000 && leds_now !== leds_prev)
        observe(K_LEDON, {leds_now, player_score, computer_score});
      if (clear_choice) observe(K_CLR, {leds_now, player_score, computer_score});
      if (leds_now == 3'b000 && leds_prev != 3'b000)
        observe(K_LEDOFF, {leds_now, player_score, computer_score});
      if (match_over && !over_prev)
        observe(K_DONE, {2'b00, match_winner, player_score, computer_score});
      leds_prev <= leds_now;
      over_prev <= match_over;
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) tick();
  endtask

  // One round starting with the DUT in WAIT_CHOICE; returns at the cycle after SHOW.
  task automatic play(input logic [1:0] p, input logic [1:0] c, input int nulls,
                      input logic [2:0] led, input logic [2:0] ps, input logic [2:0] cs,
                      input bit ends, input bit winner);
    int k;
    int e;
    k = cyc;
    player_choice   = p;
    computer_choice = (nulls > 0) ? 2'b00 : c;
    for (int i = 0; i <= nulls; i++) push(K_STOP, k + C + 1 + 2 * i, 9'd0);
    e = k + C + 2 + 2 * nulls;
    push(K_LEDON, e + 1, {led, ps, cs});
    push(K_CLR, e + S, {led, ps, cs});
    push(K_LEDOFF, e + S + 1, {3'b000, ps, cs});
    if (ends) push(K_DONE, e + S + 1, {2'b00, winner, ps, cs});
    wait_until(k + C + 1 + 2 * nulls);
    computer_choice = c;
    wait_until(e);
    player_choice = 2'b00;
    wait_until(e + S + 1);
  endtask

  initial begin
    int k;
    reset = 1'b1;
    start = 1'b1;
    player_choice   = 2'b00;
    computer_choice = 2'b00;
    repeat (3) tick();
    reset = 1'b0;
    start = 1'b0;
    mon_en = 1'b1;
    check("reset_outputs", 32'(outs()), 32'd0);

    // Reset beat start: a held choice must not start a round from IDLE.
    player_choice = 2'b01;
    repeat (8) tick();
    player_choice = 2'b00;
    check("idle_ignores_choice", 32'(outs()), 32'd0);

    start = 1'b1;
    tick();
    start = 1'b0;
    check("start_to_wait", 32'(outs()), 32'd0);

    play(2'b10, 2'b10, 0, 3'b001, 3'd0, 3'd0, 1'b0, 1'b0);  // tie
    play(2'b01, 2'b11, 0, 3'b100, 3'd1, 3'd0, 1'b0, 1'b0);  // rock beats scissors

    // Drop in the same cycle the counter reaches zero: no lock.
    k = cyc;
    player_choice = 2'b01;
    wait_until(k + C);
    player_choice = 2'b00;
    wait_until(k + C + 1);
    play(2'b01, 2'b10, 0, 3'b010, 3'd1, 3'd1, 1'b0, 1'b0);  // paper beats rock

    start = 1'b1;  // ignored mid-match
    play(2'b11, 2'b01, 0, 3'b010, 3'd1, 3'd2, 1'b0, 1'b0);  // rock beats scissors
    start = 1'b0;

    // Abandoned countdown, then a fresh choice.
    k = cyc;
    player_choice = 2'b01;
    wait_until(k + 2);
    player_choice = 2'b00;
    wait_until(k + 3);
    play(2'b11, 2'b10, 0, 3'b100, 3'd2, 3'd2, 1'b0, 1'b0);  // scissors beats paper

    // Two lock retries, then the match-winning round.
    play(2'b11, 2'b10, 2, 3'b100, 3'd3, 3'd2, 1'b1, 1'b1);
    check("done_flags_scores", {26'd0, match_over, match_winner, player_score, computer_score},
          {26'd0, 1'b1, 1'b1, 3'd3, 3'd2});
    repeat (3) tick();
    check("done_holds", 32'(outs()), 32'(14'b00000_011_010_11));

    start = 1'b1;
    tick();
    start = 1'b0;
    check("restart_clears", 32'(outs()), 32'd0);

    // Reset in the middle of a losing round's SHOW.
    k = cyc;
    player_choice   = 2'b01;
    computer_choice = 2'b10;
    push(K_STOP, k + C + 1, 9'd0);
    push(K_LEDON, k + C + 3, {3'b010, 3'd0, 3'd1});
    push(K_LEDOFF, k + C + 6, 9'd0);
    wait_until(k + C + 5);
    check("lose_led_before_reset", 32'(lose_led), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("reset_mid_show", 32'(outs()), 32'd0);
    repeat (10) tick();
    check("idle_after_reset", 32'(outs()), 32'd0);
    player_choice = 2'b00;
    start = 1'b1;
    tick();
    start = 1'b0;
    play(2'b01, 2'b11, 0, 3'b100, 3'd1, 3'd0, 1'b0, 1'b0);

    repeat (4) tick();
    check("events_pending", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/rps_match_sequencer.md
# rps_match_sequencer

Best-of-N match controller for the Rock-Paper-Scissors game. It sequences each round through the same resources the game controller already uses: wait for a player choice, run a lock-in countdown, pulse `stop_signal` to freeze the computer choice, score the round, and display the result. It keeps running scores until one side reaches the win target. It sits between the player/computer choice blocks and the LED/score outputs, and it replaces the free-running stop button.

## Interface
Parameters:
- `WIN_TARGET`, default 3: rounds needed to win the match; legal range 1..7.
- `COUNTDOWN_CYCLES`, default 4: cycles the player choice must stay stable before lock; must be 1 or more.
- `SHOW_CYCLES`, default 8: cycles the round result is displayed; must be 1 or more.

Ports:
- `clock` in 1: the single clock. All logic is on its rising edge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: level-sampled. Starts a new match when in IDLE or DONE.
- `player_choice` in 2: 00 none, 01 rock, 10 paper, 11 scissors.
- `computer_choice` in 2: same encoding. Must be valid the cycle after `stop_signal`.
- `stop_signal` out 1: one-cycle pulse that locks the computer choice.
- `clear_choice` out 1: one-cycle pulse that clears the player choice latch.
- `win_led`, `lose_led`, `tie_led` out 1 each: result of the current round. At most one is high.
- `player_score`, `computer_score` out 3 each: round wins in the current match.
- `match_over` out 1: high while in DONE.
- `match_winner` out 1: 1 means the player won the match. Valid only while `match_over` is high.

## Operation
- States: IDLE, WAIT_CHOICE, COUNTDOWN, LOCK, EVAL, SHOW, DONE.
- IDLE:
  - All outputs are 0.
  - `start` moves to WAIT_CHOICE and clears both scores.
- WAIT_CHOICE:
  - LEDs are 0.
  - `player_choice` != 00 loads the countdown counter with COUNTDOWN_CYCLES-1 and moves to COUNTDOWN.
- COUNTDOWN:
  - If `player_choice` returns to 00, go back to WAIT_CHOICE. The counter is discarded.
  - A change between nonzero values does not restart the count; the last value is used.
  - At counter 0, register `player_choice` into `p_lock` and move to LOCK.
- LOCK:
  - `stop_signal` = 1 for exactly this cycle.
  - Always moves to EVAL.
- EVAL:
  - Samples `computer_choice`.
  - If it is 00, return to LOCK. This retries the lock and re-pulses `stop_signal`; the scores do not change.
  - Otherwise compute the outcome:
    - rock beats scissors, paper beats rock, scissors beats paper;
    - equal choices are a tie.
  - Increment the winner's score; a tie changes neither score.
  - Register the matching LED and move to SHOW.
- SHOW:
  - The LED holds for SHOW_CYCLES cycles.
  - `clear_choice` = 1 in the last SHOW cycle.
  - Then go to DONE if either score equals WIN_TARGET, else to WAIT_CHOICE. LEDs clear on leaving SHOW.
- DONE:
  - `match_over` = 1 and `match_winner` = (`player_score` == WIN_TARGET).
  - Scores hold. LEDs are 0.
  - `start` clears the scores and `match_over` and moves to WAIT_CHOICE.
- `start` is ignored outside IDLE and DONE.
- Scores never exceed WIN_TARGET and never wrap, because a match ends when one reaches the target.

## Timing
- Reset, in any state including mid-countdown or mid-SHOW:
  - next state is IDLE;
  - all outputs are 0, including scores, `stop_signal`, `clear_choice` and `match_over`.
- `start` sampled high at cycle N (in IDLE) puts the block in WAIT_CHOICE at N+1.
- Nonzero `player_choice` sampled at cycle N (in WAIT_CHOICE) gives:
  - COUNTDOWN for cycles N+1 .. N+C, where C = COUNTDOWN_CYCLES;
  - `stop_signal` high at cycle N+C+1;
  - EVAL, sampling `computer_choice`, at N+C+2;
  - LED and score updates visible at N+C+3;
  - `clear_choice` at N+C+2+SHOW_CYCLES.
- Only registered outputs; no combinational path from input to output.
- Reset and `start` in the same cycle: reset wins.
- A `player_choice` drop in the same cycle the counter hits 0: the drop wins, and the block returns to WAIT_CHOICE with no lock.

## Test plan
- Reset, then `start`, then hold `player_choice` = 01 with `computer_choice` = 11 (defaults):
  - `stop_signal` pulses exactly once, 5 cycles after the choice;
  - `win_led` is high for 8 cycles;
  - `player_score` = 1;
  - `clear_choice` is a single pulse in the last LED cycle.
- Player 10 versus computer 10: `tie_led` for 8 cycles; both scores are unchanged at 0.
- Player 01 held for 2 cycles, then 00, then 11 held:
  - no `stop_signal` after the first attempt;
  - the countdown restarts, and `stop_signal` comes 5 cycles after the 11.
- `computer_choice` = 00 at EVAL for 2 lock attempts, then 10, with player 11:
  - `stop_signal` pulses 3 times in total;
  - one win is scored.
- Player wins 3 rounds while the computer wins 2:
  - after the 3rd player win's SHOW, `match_over` = 1, `match_winner` = 1, scores read 3/2;
  - `start` then clears the scores to 0/0.
- Assert `reset` during SHOW with `lose_led` high: next cycle all outputs are 0 and the state is IDLE; `start` is required to resume.
